// File: rtl/adder_array_pipe.sv
// Registered multi-lane adder array: add / sub / per-lane accumulate / clear,
// with cmd-based lane selection, valid/ready on both sides and sticky overflow flags.
module adder_array_pipe #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int CMD_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CMD_W-1:0]         cmd,
    input  logic [1:0]               op,
    input  logic [LANES*WIDTH-1:0]   ain,
    input  logic [LANES*WIDTH-1:0]   bin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   dout,
    output logic [LANES-1:0]         overflow,
    output logic [LANES-1:0]         ovf_sticky,
    input  logic                     sticky_clr
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic                   accept;
    logic [LANES-1:0]       en;
    logic [LANES*WIDTH-1:0] res_d;
    logic [LANES-1:0]       res_o;

    // The rst term keeps the source unblocked while a stalled result is being discarded.
    assign in_ready = rst || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] a_l;
        logic [WIDTH-1:0] b_l;
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   diff;
        logic [WIDTH:0]   acc_sum;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] acc_nx;
        logic [WIDTH-1:0] lane_d;
        logic             lane_o;

        assign a_l     = ain[i*WIDTH +: WIDTH];
        assign b_l     = bin[i*WIDTH +: WIDTH];
        assign en[i]   = (cmd == CMD_W'(i)) || (cmd == CMD_W'(LANES));
        assign sum     = {1'b0, a_l} + {1'b0, b_l};
        // Top bit of the widened difference is the borrow (a < b).
        assign diff    = {1'b0, a_l} - {1'b0, b_l};
        assign acc_sum = {1'b0, acc} + {1'b0, a_l};

        always_comb begin
            lane_d = '0;
            lane_o = 1'b0;
            acc_nx = acc;
            if (en[i]) begin
                unique case (op)
                    OP_ADD: begin
                        lane_d = sum[WIDTH-1:0];
                        lane_o = sum[WIDTH];
                    end
                    OP_SUB: begin
                        lane_d = diff[WIDTH-1:0];
                        lane_o = diff[WIDTH];
                    end
                    OP_ACC: begin
                        acc_nx = acc_sum[WIDTH-1:0];
                        lane_d = acc_sum[WIDTH-1:0];
                        lane_o = acc_sum[WIDTH];
                    end
                    OP_CLR: begin
                        acc_nx = '0;
                    end
                    default: begin
                        acc_nx = acc;
                    end
                endcase
            end
        end

        assign res_d[i*WIDTH +: WIDTH] = lane_d;
        assign res_o[i]                = lane_o;

        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
            end else if (accept) begin
                acc <= acc_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            dout       <= '0;
            overflow   <= '0;
            ovf_sticky <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                dout      <= res_d;
                overflow  <= res_o;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Set beats clear when both hit the same bit.
            ovf_sticky <= (ovf_sticky & ~{LANES{sticky_clr}}) | (accept ? res_o : '0);
        end
    end

endmodule

// File: tb/tb_adder_array_pipe.sv
// Self-checking bench for adder_array_pipe: vector table, hand sequences for
// backpressure / sticky / reset, and a randomised run, all through a scoreboard queue.
module tb_adder_array_pipe;

    localparam int LANES = 4;
    localparam int WIDTH = 32;
    localparam int CMD_W = 5;
    localparam int DW    = LANES * WIDTH;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [CMD_W-1:0]   cmd;
    logic [1:0]         op;
    logic [DW-1:0]      ain;
    logic [DW-1:0]      bin;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      dout;
    logic [LANES-1:0]   overflow;
    logic [LANES-1:0]   ovf_sticky;
    logic               sticky_clr;

    adder_array_pipe #(.LANES(LANES), .WIDTH(WIDTH), .CMD_W(CMD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmd        (cmd),
        .op         (op),
        .ain        (ain),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky),
        .sticky_clr (sticky_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]    d;
        logic [LANES-1:0] o;
    } res_t;

    typedef struct {
        logic [CMD_W-1:0] cmd;
        logic [1:0]       op;
        logic [DW-1:0]    a;
        logic [DW-1:0]    b;
        logic [DW-1:0]    ed;
        logic [LANES-1:0] eo;
    } vec_t;

    res_t             sbq[$];
    logic [WIDTH-1:0] m_acc[LANES];
    logic [LANES-1:0] m_sticky;
    logic             m_valid;
    int               n_checks = 0;
    int               n_fail   = 0;

    function automatic logic [DW-1:0] pk(input logic [31:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference behaviour of one accepted bundle; updates the model accumulators.
    task automatic model_step(input logic [CMD_W-1:0] c, input logic [1:0] o,
                              input logic [DW-1:0] a, input logic [DW-1:0] b,
                              output res_t r);
        logic [WIDTH-1:0] al, bl;
        logic [WIDTH:0]   t;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!(c == CMD_W'(i) || c == CMD_W'(LANES))) continue;
            al = a[i*WIDTH +: WIDTH];
            bl = b[i*WIDTH +: WIDTH];
            case (o)
                2'd0: begin
                    t = (WIDTH+1)'(al) + (WIDTH+1)'(bl);
                    r.d[i*WIDTH +: WIDTH] = t[WIDTH-1:0];
                    r.o[i] = t[WIDTH];
                end
                2'd1: begin
                    r.d[i*WIDTH +: WIDTH] = al - bl;
                    r.o[i] = (al < bl);
                end
                2'd2: begin
                    t = (WIDTH+1)'(m_acc[i]) + (WIDTH+1)'(al);
                    m_acc[i] = t[WIDTH-1:0];
                    r.d[i*WIDTH +: WIDTH] = t[WIDTH-1:0];
                    r.o[i] = t[WIDTH];
                end
                default: m_acc[i] = '0;
            endcase
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input logic v, input logic [CMD_W-1:0] c, input logic [1:0] o,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic ordy, input logic sclr,
                         input logic use_exp, input res_t e);
        res_t r, got, pushed;
        logic acc;
        in_valid   = v;
        cmd        = c;
        op         = o;
        ain        = a;
        bin        = b;
        out_ready  = ordy;
        sticky_clr = sclr;
        #1;
        chk("in_ready", in_ready, !m_valid || ordy);
        if (m_valid && ordy) begin
            if (sbq.size() == 0) begin
                chk("scoreboard_underflow", 1'b1, 1'b0);
            end else begin
                got = sbq.pop_front();
                chk("dout", dout, got.d);
                chk("overflow", overflow, got.o);
            end
        end
        acc    = v && (!m_valid || ordy);
        pushed = '0;
        if (acc) begin
            model_step(c, o, a, b, r);
            pushed = use_exp ? e : r;
            sbq.push_back(pushed);
        end
        m_sticky = (m_sticky & ~{LANES{sclr}}) | pushed.o;
        if (acc) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("ovf_sticky", ovf_sticky, m_sticky);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ordy);
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = ordy;
        sticky_clr = 1'b0;
        #1;
        chk("in_ready_in_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dout", dout, '0);
        chk("rst_overflow", overflow, '0);
        chk("rst_sticky", ovf_sticky, '0);
        rst = 1'b0;
        for (int i = 0; i < LANES; i++) m_acc[i] = '0;
        m_valid  = 1'b0;
        m_sticky = '0;
        sbq.delete();
        @(negedge clk);
    endtask

    vec_t tbl[12];

    initial begin
        res_t e;
        logic [CMD_W-1:0] rc;
        logic [DW-1:0] ra, rb;
        int sel;

        rst = 1'b1; in_valid = 1'b0; cmd = '0; op = '0; ain = '0; bin = '0;
        out_ready = 1'b1; sticky_clr = 1'b0;
        m_valid = 1'b0; m_sticky = '0;
        for (int i = 0; i < LANES; i++) m_acc[i] = '0;

        tbl[0]  = '{5'd4,  2'd0, pk(0, 0, 5, 32'hFFFF_FFFF), pk(0, 0, 7, 1), pk(0, 0, 12, 0), 4'b0001};
        tbl[1]  = '{5'd2,  2'd1, pk(7, 3, 8, 9), pk(1, 5, 2, 4), pk(0, 32'hFFFF_FFFE, 0, 0), 4'b0100};
        tbl[2]  = '{5'd1,  2'd2, pk(1, 1, 10, 1), pk(3, 3, 3, 3), pk(0, 0, 10, 0), 4'b0000};
        tbl[3]  = '{5'd1,  2'd2, pk(1, 1, 20, 1), pk(3, 3, 3, 3), pk(0, 0, 30, 0), 4'b0000};
        tbl[4]  = '{5'd1,  2'd2, pk(1, 1, 32'hFFFF_FFF0, 1), pk(3, 3, 3, 3), pk(0, 0, 32'h0000_000E, 0), 4'b0010};
        tbl[5]  = '{5'd1,  2'd3, pk(1, 1, 1, 1), pk(3, 3, 3, 3), pk(0, 0, 0, 0), 4'b0000};
        tbl[6]  = '{5'd1,  2'd2, pk(9, 9, 4, 9), pk(3, 3, 3, 3), pk(0, 0, 4, 0), 4'b0000};
        tbl[7]  = '{5'd5,  2'd0, pk(32'hFFFF_FFFF, 6, 7, 8), pk(1, 1, 1, 1), pk(0, 0, 0, 0), 4'b0000};
        tbl[8]  = '{5'd31, 2'd2, pk(5, 5, 5, 5), pk(1, 1, 1, 1), pk(0, 0, 0, 0), 4'b0000};
        tbl[9]  = '{5'd4,  2'd1, pk(0, 9, 5, 100), pk(1, 9, 6, 1), pk(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 99), 4'b1010};
        tbl[10] = '{5'd4,  2'd2, pk(1, 2, 3, 4), pk(7, 7, 7, 7), pk(1, 2, 7, 4), 4'b0000};
        tbl[11] = '{5'd4,  2'd3, pk(1, 2, 3, 4), pk(7, 7, 7, 7), pk(0, 0, 0, 0), 4'b0000};

        @(negedge clk);
        do_reset(1'b1);

        // Vector table, back-to-back at full rate.
        for (int k = 0; k < 12; k++) begin
            e.d = tbl[k].ed;
            e.o = tbl[k].eo;
            cycle(1'b1, tbl[k].cmd, tbl[k].op, tbl[k].a, tbl[k].b, 1'b1, 1'b0, 1'b1, e);
        end
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("table_drained", 32'(sbq.size()), 32'd0);

        // Backpressure: first bundle accepted, second held until out_ready rises.
        cycle(1'b1, 5'd0, 2'd0, pk(0, 0, 0, 1), pk(0, 0, 0, 1), 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 5'd0, 2'd0, pk(0, 0, 0, 2), pk(0, 0, 0, 2), 1'b0, 1'b0, 1'b0, '0);
        chk("bp_hold_1", dout, pk(0, 0, 0, 2));
        cycle(1'b1, 5'd0, 2'd0, pk(0, 0, 0, 2), pk(0, 0, 0, 2), 1'b0, 1'b0, 1'b0, '0);
        chk("bp_hold_2", dout, pk(0, 0, 0, 2));
        cycle(1'b1, 5'd0, 2'd0, pk(0, 0, 0, 2), pk(0, 0, 0, 2), 1'b1, 1'b0, 1'b0, '0);
        chk("bp_second", dout, pk(0, 0, 0, 4));
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("bp_drained", 32'(sbq.size()), 32'd0);

        // Sticky: clear and set on the same bit, then clear alone.
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 5'd3, 2'd0, pk(32'hFFFF_FFFF, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b1, 1'b0, '0);
        chk("sticky_set_wins", ovf_sticky[3], 1'b1);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
        chk("sticky_cleared", ovf_sticky[3], 1'b0);

        // Reset with a stalled result holding acc lane0 = 100.
        e.d = pk(0, 0, 0, 100);
        e.o = '0;
        cycle(1'b1, 5'd0, 2'd2, pk(0, 0, 0, 100), '0, 1'b0, 1'b0, 1'b1, e);
        do_reset(1'b0);
        e.d = pk(0, 0, 0, 1);
        cycle(1'b1, 5'd0, 2'd2, pk(0, 0, 0, 1), '0, 1'b1, 1'b0, 1'b1, e);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);

        // Randomised traffic checked against the model.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 7));
            rc  = (sel <= LANES + 1) ? CMD_W'(sel) : 5'd31;
            for (int i = 0; i < LANES; i++) begin
                ra[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                rb[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            cycle(1'($urandom_range(0, 3) != 0), rc, 2'($urandom_range(0, 3)), ra, rb,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0), 1'b0, '0);
        end
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        end
        chk("random_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_array_pipe.md
Name: adder_array_pipe

Overview:
- Parametrised, registered successor of the four-lane combinational adder array.
- LANES independent WIDTH-bit lanes with four operations: add, subtract, per-lane accumulate and accumulator clear.
- Lane selection by cmd, valid/ready handshake on both sides, and a one-deep output register, so it drops into the streaming datapath between operand fetch and writeback.
- Also provides per-lane sticky overflow flags.

Parameters:
- LANES, 4, number of parallel lanes (1..16).
- WIDTH, 32, bits per operand / result per lane.
- CMD_W, 5, cmd width; must satisfy 2**CMD_W > LANES.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- cmd  in  CMD_W  lane select: value k<LANES selects lane k only; value LANES selects all lanes; anything else selects no lane.
- op  in  2  00 add, 01 sub, 10 accumulate, 11 clear accumulator.
- ain  in  LANES*WIDTH  lane i operand A at bits [i*WIDTH +: WIDTH].
- bin  in  LANES*WIDTH  lane i operand B, same packing.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts the result this cycle.
- dout  out  LANES*WIDTH  per-lane results, same packing.
- overflow  out  LANES  per-lane flag for the current result.
- ovf_sticky  out  LANES  per-lane OR of all overflows since last clear.
- sticky_clr  in  1  clear ovf_sticky.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, dout=0, overflow=0, ovf_sticky=0, all accumulators=0. Reset overrides any transfer in the same cycle and discards an in-flight result.
- in_ready = !out_valid || out_ready (combinational). It is 1 while rst is held.
- Accept = in_valid && in_ready. On accept, the output register loads at the next edge, so latency is 1 cycle. Back-to-back accepts sustain 1 result per cycle while out_ready=1.
- Output side:
  - If out_valid && out_ready && !accept: out_valid goes to 0 next edge; dout and overflow hold their value.
  - If out_valid && !out_ready: dout, overflow and out_valid are held stable; no accumulator changes.
- Lane enable en[i] = (cmd==i) || (cmd==LANES). Disabled lanes on accept: dout lane = 0, overflow lane = 0, accumulator unchanged.
- Enabled-lane arithmetic, all unsigned and modulo 2**WIDTH:
  - op=00: dout = ain + bin; overflow = carry out of bit WIDTH-1.
  - op=01: dout = ain - bin; overflow = borrow (ain < bin).
  - op=10: acc <= acc + ain; dout = the new acc value; overflow = carry. bin is ignored.
  - op=11: acc <= 0; dout = 0; overflow = 0.
- Each accumulator is WIDTH bits and wraps on overflow.
- Sticky flags: on accept, ovf_sticky[i] is ORed with the new overflow[i]. sticky_clr=1 clears all bits. If a clear and a set hit the same bit in the same cycle, the set wins (the bit ends 1).
- Invalid cmd (cmd > LANES) is still a legal transfer: it produces a result with all lanes 0 and out_valid asserted.
- in_valid with in_ready=0: the input is not consumed; the source must hold it.

Test Plan:
- Reset, then cmd=LANES, op=00, lane0 0xFFFFFFFF+0x1, lane1 5+7 -> one cycle later out_valid=1; lane0 dout=0 with overflow[0]=1; lane1 dout=12 with overflow[1]=0; ovf_sticky=4'b0001.
- cmd=2, op=01, lane2 3-5, other lanes nonzero -> lane2 dout=0xFFFFFFFE, overflow[2]=1; all other lanes dout=0 and overflow=0.
- Accumulate, cmd=1, op=10, ain lane1 = 10, 20, 0xFFFFFFF0 on consecutive accepts -> dout lane1 = 10, 30, then 0x0000000E with overflow[1]=1. Then op=11 followed by op=10 ain=4 -> dout lane1 = 0, then 4.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept; dout held stable; the second bundle is accepted only in the cycle out_ready rises; no result is lost or duplicated.
- Sticky: force overflow on lane3 while sticky_clr=1 in the same cycle -> ovf_sticky[3]=1. Next cycle sticky_clr=1 with no overflow -> ovf_sticky[3]=0.
- Reset mid-stream: out_valid=1 with acc lane0=100, assert rst one cycle -> out_valid=0, dout=0, acc=0. A following op=10 with ain=1 gives dout lane0=1.
